// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ID->EX->MEM->WB control pipeline.
// Holds the per-stage control payload and the forwarding-select encoding.
// The forwarding helper is shared so both EX operands use one rule.
package ctrl_pkg;

  // Register address width of the stage payload; the top-level AW must match it.
  localparam int REG_AW = 5;

  // ALU operation classes produced by the decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // EX operand source selects.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Primary opcodes of the instructions this control path understands.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Control payload carried by each pipeline stage register.
  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [REG_AW-1:0] waddr;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ctrl_bundle_t;

  // A bubble is an all-zero payload: invalid, no side effects, waddr 0.
  localparam ctrl_bundle_t BUBBLE = '0;

  // Operand source for one EX register field; the younger producer in MEM wins over WB.
  function automatic logic [1:0] fwd_sel(input ctrl_bundle_t mem_s,
                                         input ctrl_bundle_t wb_s,
                                         input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_s.valid && mem_s.reg_write && (mem_s.waddr == src)) begin
      sel = FWD_MEM;
    end else if (wb_s.valid && wb_s.reg_write && (wb_s.waddr == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register for the control payload.
// Latency 1 cycle; hold_i freezes the content, bubble_i loads an all-zero payload.
// Asynchronous active-low clear drops whatever is in flight.
module ctrl_stage_reg
  import ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  ctrl_bundle_t d_i,
  output ctrl_bundle_t q_o
);

  ctrl_bundle_t payload_d;
  ctrl_bundle_t payload_q;

  // Next payload: hold has priority, then bubble, else take the upstream stage.
  always_comb begin
    payload_d = payload_q;
    if (!hold_i) begin
      payload_d = bubble_i ? BUBBLE : d_i;
    end
  end

  // Payload flop with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      payload_q <= BUBBLE;
    end else begin
      payload_q <= payload_d;
    end
  end

  assign q_o = payload_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline ID->EX->MEM->WB with load-use hazard detection and EX forwarding selects.
// Latency: an instruction presented in ID reaches WB 3 cycles later.
// mem_stall_i freezes every stage; a load-use hazard holds upstream and injects one EX bubble.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int AW    = REG_AW,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic             RegDst_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemToReg_i,
  input  logic             MemWrite_i,
  input  logic [AW-1:0]    id_rs_i,
  input  logic [AW-1:0]    id_rt_i,
  input  logic [AW-1:0]    id_rd_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_valid_o,
  output logic             mem_MemWrite_o,
  output logic             wb_valid_o,
  output logic             wb_RegWrite_o,
  output logic             wb_MemToReg_o,
  output logic [AW-1:0]    wb_waddr_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_bundle_t    id_bundle;
  ctrl_bundle_t    ex_q;
  ctrl_bundle_t    mem_q;
  ctrl_bundle_t    wb_q;
  logic [AW-1:0]   id_waddr;
  logic            hazard;
  logic            ex_bubble;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic            unused_wb;

  // Build the ID payload; a write to $0 is dropped here so $0 never hazards or forwards.
  always_comb begin
    id_waddr             = RegDst_i ? id_rd_i : id_rt_i;
    id_bundle            = BUBBLE;
    id_bundle.valid      = 1'b1;
    id_bundle.alu_op     = ALUOp_i;
    id_bundle.alu_src    = ALUSrc_i;
    id_bundle.reg_write  = RegWrite_i & (id_waddr != '0);
    id_bundle.mem_to_reg = MemToReg_i;
    id_bundle.mem_write  = MemWrite_i;
    id_bundle.waddr      = id_waddr;
    id_bundle.rs         = id_rs_i;
    id_bundle.rt         = id_rt_i;
  end

  // Load in EX feeding a source of the ID instruction; rt only counts when it is read.
  always_comb begin
    hazard = id_valid_i & ex_q.valid & ex_q.mem_to_reg & ex_q.reg_write &
             ((ex_q.waddr == id_rs_i) |
              ((ex_q.waddr == id_rt_i) & (~ALUSrc_i | MemWrite_i)));
    ex_bubble = hazard | flush_i | ~id_valid_i;
  end

  assign stall_o = hazard | mem_stall_i;

  ctrl_stage_reg u_ex_reg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .hold_i   (mem_stall_i),
    .bubble_i (ex_bubble),
    .d_i      (id_bundle),
    .q_o      (ex_q)
  );

  ctrl_stage_reg u_mem_reg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .hold_i   (mem_stall_i),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  ctrl_stage_reg u_wb_reg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .hold_i   (mem_stall_i),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // Count hazard bubbles on advancing edges only, saturating at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!mem_stall_i && hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Bubble counter flop with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Forwarding selects for both EX operands; idle when EX holds a bubble.
  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (ex_q.valid) begin
      fwd_a_o = fwd_sel(mem_q, wb_q, ex_q.rs);
      fwd_b_o = fwd_sel(mem_q, wb_q, ex_q.rt);
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_ALUOp_o     = ex_q.alu_op;
  assign ex_ALUSrc_o    = ex_q.alu_src;
  assign mem_valid_o    = mem_q.valid;
  assign mem_MemWrite_o = mem_q.mem_write;
  assign wb_valid_o     = wb_q.valid;
  assign wb_RegWrite_o  = wb_q.reg_write;
  assign wb_MemToReg_o  = wb_q.mem_to_reg;
  assign wb_waddr_o     = wb_q.waddr;
  assign bubble_cnt_o   = bubble_cnt_q;

  // Fields that have no consumer once the instruction reaches WB.
  assign unused_wb = ^{wb_q.alu_op, wb_q.alu_src, wb_q.mem_write, wb_q.rs, wb_q.rt};

endmodule
